// File: rtl/mfi_crc_pkg.sv
// Shared CRC-32/IEEE constants and the controller state encoding for image
// integrity checkers.
package mfi_crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;
  localparam logic [31:0] WORD_BYTES      = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } crc_state_t;

endpackage

// File: rtl/crc32_d32.sv
// Combinational CRC-32 (reflected) update over one 32-bit little-endian word:
// byte [7:0] first, each byte LSB first.
module crc32_d32
  import mfi_crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_next
);

  // NOTE: every variable assigned in always_comb gets a value on every path
  // before it is read, otherwise synthesis infers a latch.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ data;
    // In reflected form the whole word can be XORed in first and then shifted
    // out bit by bit; this equals four byte-wise LSB-first steps.
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/image_crc_calc.sv
// Reads a fixed memory region through a pipelined Avalon-MM master and
// produces its CRC-32 for the device-information register block.
module image_crc_calc
  import mfi_crc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned WORD_COUNT = 1024,
  parameter int unsigned MAX_PEND   = 4,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        crc_valid,
  output logic [31:0] crc_out
);

  localparam int CNT_W  = $clog2(WORD_COUNT + 1);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  localparam logic [CNT_W-1:0]  WC       = CNT_W'(WORD_COUNT);
  localparam logic [CNT_W-1:0]  WC_LAST  = CNT_W'(WORD_COUNT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  crc_state_t        state;
  crc_state_t        next_state;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  received;
  logic [CNT_W-1:0]  received_nxt;
  logic [PEND_W-1:0] pending;
  logic [31:0]       crc_reg;
  logic [31:0]       crc_fold;
  logic              run_start;
  logic              accept;
  logic              rdv_ok;
  logic              start_pend;
  logic              auto_pend;

  crc32_d32 u_crc32_d32 (
    .crc_in   (crc_reg),
    .data     (avm_readdata),
    .crc_next (crc_fold)
  );

  assign busy   = (state == READ) || (state == DRAIN);
  assign accept = avm_read && !avm_waitrequest;

  // Data is only counted against an outstanding request, so stale responses
  // left over from an aborted run cannot advance the new one.
  assign rdv_ok       = avm_readdatavalid && busy && (pending != '0);
  assign received_nxt = received + CNT_W'(rdv_ok);

  always_comb begin
    next_state = state;
    run_start  = 1'b0;
    avm_read   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start || start_pend || auto_pend) begin
          next_state = READ;
          run_start  = 1'b1;
        end
      end
      READ: begin
        avm_read = (pending < PEND_MAX) && (issued < WC);
        if (avm_read && !avm_waitrequest && (issued == WC_LAST)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (received_nxt == WC) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address <= BASE_ADDR;
      issued      <= '0;
      received    <= '0;
      pending     <= '0;
      crc_reg     <= CRC32_INIT;
      crc_valid   <= 1'b0;
      crc_out     <= '0;
      start_pend  <= 1'b0;
      auto_pend   <= AUTO_START;
    end else if (run_start) begin
      avm_address <= BASE_ADDR;
      issued      <= '0;
      received    <= '0;
      pending     <= '0;
      crc_reg     <= CRC32_INIT;
      crc_valid   <= 1'b0;
      start_pend  <= 1'b0;
      auto_pend   <= 1'b0;
    end else begin
      if (accept) begin
        issued      <= issued + 1'b1;
        avm_address <= avm_address + WORD_BYTES;
      end
      if (rdv_ok) begin
        received <= received_nxt;
        crc_reg  <= crc_fold;
      end
      pending <= pending + PEND_W'(accept) - PEND_W'(rdv_ok);
      if (state == DONE) begin
        crc_out   <= crc_reg ^ CRC32_XOROUT;
        crc_valid <= 1'b1;
        // A request arriving as the run finishes is kept for the next IDLE.
        if (start) begin
          start_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_crc_calc.sv
// Self-checking bench: three controller instances against randomized Avalon
// slaves and a table-driven CRC-32 reference model.
module tb_image_crc_calc;

  localparam logic [31:0] BASE_A = 32'h0000_0080;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam logic [31:0] BASE_C = 32'hFFFF_FFF8;
  localparam int WC_A   = 1;
  localparam int WC_B   = 16;
  localparam int WC_C   = 4;
  localparam int PEND_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [3];
  logic        start   [3];
  logic        wr      [3];
  logic        rdv     [3];
  logic [31:0] rdata   [3];
  logic [31:0] o_addr  [3];
  logic        o_read  [3];
  logic        o_busy  [3];
  logic        o_valid [3];
  logic [31:0] o_crc   [3];

  logic [31:0] mem     [64];
  logic [31:0] crc_tab [256];
  logic [31:0] base_of [3];
  int          wc_of   [3];
  bit          wait_en [3];
  bit          lat_rand[3];
  int          acc_cnt [3];
  int          acc_err [3];
  int          max_pend_seen [3];
  logic [31:0] rb_data [3][16];
  int          rb_due  [3][16];
  int          rb_head [3];
  int          rb_cnt  [3];
  int          cyc;
  int          n_tests;
  int          n_fail;

  image_crc_calc #(.BASE_ADDR(BASE_A), .WORD_COUNT(WC_A), .MAX_PEND(4), .AUTO_START(1'b0)) dut_a (
    .clk(clk), .reset_n(rst_n[0]), .start(start[0]),
    .avm_address(o_addr[0]), .avm_read(o_read[0]), .avm_waitrequest(wr[0]),
    .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
    .busy(o_busy[0]), .crc_valid(o_valid[0]), .crc_out(o_crc[0]));

  image_crc_calc #(.BASE_ADDR(BASE_B), .WORD_COUNT(WC_B), .MAX_PEND(PEND_B), .AUTO_START(1'b1)) dut_b (
    .clk(clk), .reset_n(rst_n[1]), .start(start[1]),
    .avm_address(o_addr[1]), .avm_read(o_read[1]), .avm_waitrequest(wr[1]),
    .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
    .busy(o_busy[1]), .crc_valid(o_valid[1]), .crc_out(o_crc[1]));

  image_crc_calc #(.BASE_ADDR(BASE_C), .WORD_COUNT(WC_C), .MAX_PEND(2), .AUTO_START(1'b0)) dut_c (
    .clk(clk), .reset_n(rst_n[2]), .start(start[2]),
    .avm_address(o_addr[2]), .avm_read(o_read[2]), .avm_waitrequest(wr[2]),
    .avm_readdata(rdata[2]), .avm_readdatavalid(rdv[2]),
    .busy(o_busy[2]), .crc_valid(o_valid[2]), .crc_out(o_crc[2]));

  // Avalon slave models: decisions made mid-cycle, sampled by the next posedge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 3; g++) begin
      int wi;
      rdv[g]   = 1'b0;
      rdata[g] = $urandom;
      if (rb_cnt[g] != 0 && rb_due[g][rb_head[g]] <= cyc) begin
        rdv[g]     = 1'b1;
        rdata[g]   = rb_data[g][rb_head[g]];
        rb_head[g] = (rb_head[g] + 1) % 16;
        rb_cnt[g]  = rb_cnt[g] - 1;
      end
      wr[g] = wait_en[g] && ($urandom_range(1) == 1);
      if (o_read[g] === 1'b1 && !wr[g] && rst_n[g] === 1'b1 && rb_cnt[g] < 16) begin
        if (o_addr[g] !== base_of[g] + 32'(4 * acc_cnt[g])) acc_err[g] = acc_err[g] + 1;
        wi = (rb_head[g] + rb_cnt[g]) % 16;
        rb_data[g][wi] = mem[o_addr[g][7:2]];
        rb_due[g][wi]  = cyc + (lat_rand[g] ? int'($urandom_range(6, 1)) : 1);
        rb_cnt[g]  = rb_cnt[g] + 1;
        acc_cnt[g] = acc_cnt[g] + 1;
      end
      if (rb_cnt[g] > max_pend_seen[g]) max_pend_seen[g] = rb_cnt[g];
    end
  end

  // Reference: byte-stream CRC-32 via a 256-entry lookup table.
  function automatic logic [31:0] model_crc(input int g);
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] w;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < wc_of[g]; i++) begin
      a = base_of[g] + 32'(4 * i);
      w = mem[a[7:2]];
      for (int k = 0; k < 4; k++) begin
        c = crc_tab[c[7:0] ^ w[8*k +: 8]] ^ (c >> 8);
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic clear_mon(input int g);
    acc_cnt[g] = 0;
    acc_err[g] = 0;
    max_pend_seen[g] = 0;
  endtask

  // Returns the cycle index (start cycle = 0) at which crc_valid is seen.
  task automatic wait_valid(input int g, input int budget, output int n);
    n = 1;
    while (o_valid[g] !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    n_tests++;
    if (o_valid[g] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_valid[%0d]: crc_valid=%b after %0d cycles, required 1", g, o_valid[g], n);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0;
      start[g] = 1'b0;
    end
    repeat (3) tick();
    for (int g = 0; g < 3; g++) begin
      n_tests += 5;
      if (o_addr[g] !== base_of[g]) begin
        n_fail++; $display("FAIL reset_addr[%0d]: got %h required %h", g, o_addr[g], base_of[g]);
      end
      if (o_read[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %b required 0", g, o_read[g]);
      end
      if (o_busy[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy[%0d]: got %b required 0", g, o_busy[g]);
      end
      if (o_valid[g] !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid[%0d]: got %b required 0", g, o_valid[g]);
      end
      if (o_crc[g] !== 32'h0) begin
        n_fail++; $display("FAIL reset_crc[%0d]: got %h required 00000000", g, o_crc[g]);
      end
    end
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
  endtask

  task automatic test_idle_no_start();
    int bad;
    bad = 0;
    repeat (1000) begin
      tick();
      if (o_read[2] !== 1'b0 || o_valid[2] !== 1'b0 || o_read[0] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL idle_no_start: %0d active cycles, required 0", bad);
    end
  endtask

  task automatic check_run(input int g, input string tag);
    logic [31:0] exp_crc;
    exp_crc = model_crc(g);
    n_tests += 4;
    if (o_crc[g] !== exp_crc) begin
      n_fail++; $display("FAIL %s_crc: got %h required %h", tag, o_crc[g], exp_crc);
    end
    if (acc_cnt[g] != wc_of[g]) begin
      n_fail++; $display("FAIL %s_accepts: got %0d required %0d", tag, acc_cnt[g], wc_of[g]);
    end
    if (acc_err[g] != 0) begin
      n_fail++; $display("FAIL %s_addr_order: %0d out-of-sequence accepts, required 0", tag, acc_err[g]);
    end
    if (o_busy[g] !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got %b required 0", tag, o_busy[g]);
    end
  endtask

  task automatic test_auto_run();
    int n;
    wait_valid(1, 500, n);
    check_run(1, "auto_run");
    n_tests++;
    if (max_pend_seen[1] > PEND_B || max_pend_seen[1] == 0) begin
      n_fail++; $display("FAIL auto_run_pending: max %0d required 1..%0d", max_pend_seen[1], PEND_B);
    end
  endtask

  task automatic test_single_word(input logic [31:0] word, input logic [31:0] exp_crc, input string tag);
    int n;
    logic [31:0] a;
    a = BASE_A;
    mem[a[7:2]] = word;
    clear_mon(0);
    pulse_start(0);
    wait_valid(0, 100, n);
    check_run(0, tag);
    n_tests += 2;
    if (o_crc[0] !== exp_crc) begin
      n_fail++; $display("FAIL %s_known: got %h required %h", tag, o_crc[0], exp_crc);
    end
    if (n != WC_A + 3) begin
      n_fail++; $display("FAIL %s_latency: got %0d cycles required %0d", tag, n, WC_A + 3);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] prev;
    prev = o_crc[1];
    clear_mon(1);
    pulse_start(1);
    n_tests++;
    if (o_valid[1] !== 1'b0 || o_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart: valid=%b busy=%b required valid=0 busy=1", o_valid[1], o_busy[1]);
    end
    repeat (8) begin
      if (o_busy[1] === 1'b1 && $urandom_range(1) == 1) pulse_start(1);
      else tick();
    end
    wait_valid(1, 500, n);
    check_run(1, "b2b");
    n_tests += 2;
    if (o_crc[1] !== prev) begin
      n_fail++; $display("FAIL b2b_same_crc: got %h required %h", o_crc[1], prev);
    end
    if (max_pend_seen[1] > PEND_B) begin
      n_fail++; $display("FAIL b2b_pending: max %0d required <= %0d", max_pend_seen[1], PEND_B);
    end
  endtask

  task automatic test_start_in_done();
    int n;
    int k;
    clear_mon(1);
    pulse_start(1);
    k = 0;
    while (o_busy[1] === 1'b1 && k < 500) begin
      tick();
      k++;
    end
    n_tests++;
    if (acc_cnt[1] != WC_B || o_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL done_cycle: accepts=%0d valid=%b required %0d and 0", acc_cnt[1], o_valid[1], WC_B);
    end
    clear_mon(1);
    pulse_start(1);
    n_tests++;
    if (o_valid[1] !== 1'b1 || o_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL done_idle: valid=%b busy=%b required valid=1 busy=0", o_valid[1], o_busy[1]);
    end
    tick();
    n_tests++;
    if (o_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL done_start_taken: busy=%b required 1", o_busy[1]);
    end
    wait_valid(1, 500, n);
    check_run(1, "done_start");
  endtask

  task automatic test_reset_mid_run();
    int n;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    clear_mon(1);
    pulse_start(1);
    k = 0;
    while (acc_cnt[1] < 5 && k < 500) begin
      tick();
      k++;
    end
    rst_n[1] = 1'b0;
    #1;
    n_tests += 5;
    if (o_addr[1] !== BASE_B) begin
      n_fail++; $display("FAIL midrst_addr: got %h required %h", o_addr[1], BASE_B);
    end
    if (o_read[1] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_read: got %b required 0", o_read[1]);
    end
    if (o_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_busy: got %b required 0", o_busy[1]);
    end
    if (o_valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b required 0", o_valid[1]);
    end
    if (o_crc[1] !== 32'h0) begin
      n_fail++; $display("FAIL midrst_crc: got %h required 00000000", o_crc[1]);
    end
    repeat (10) tick();
    clear_mon(1);
    rst_n[1] = 1'b1;
    wait_valid(1, 500, n);
    check_run(1, "midrst_rerun");
  endtask

  task automatic test_wrap();
    int n;
    clear_mon(2);
    pulse_start(2);
    wait_valid(2, 500, n);
    check_run(2, "wrap");
    n_tests++;
    if (o_addr[2] !== 32'h0000_0008) begin
      n_fail++; $display("FAIL wrap_final_addr: got %h required 00000008", o_addr[2]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    base_of[0] = BASE_A; wc_of[0] = WC_A; wait_en[0] = 1'b0; lat_rand[0] = 1'b0;
    base_of[1] = BASE_B; wc_of[1] = WC_B; wait_en[1] = 1'b1; lat_rand[1] = 1'b1;
    base_of[2] = BASE_C; wc_of[2] = WC_C; wait_en[2] = 1'b1; lat_rand[2] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0;
      wr[g] = 1'b0; rdv[g] = 1'b0; rdata[g] = '0;
      rb_head[g] = 0; rb_cnt[g] = 0;
      clear_mon(g);
    end
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[n] = c;
    end
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    test_reset();
    test_idle_no_start();
    test_auto_run();
    test_single_word(32'h0000_0000, 32'h2144_DF1C, "zero_word");
    test_single_word(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones_word");
    test_back_to_back();
    test_start_in_done();
    test_reset_mid_run();
    test_wrap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
